// File: rtl/serial_subtractor_nbit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
// Latency: none (types and constants only).
// Backpressure: none.
package serial_subtractor_nbit_pkg;

    // Operand/difference width used when the instantiating level does not override it.
    localparam int DEFAULT_NUM_BITS = 4;

    // IDLE waits for start, SHIFT processes one bit per edge, DONE presents the one-cycle pulse.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_nbit_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit position must borrow.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when a == b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial unsigned subtractor: difference = a - b - borrow_in, processed LSB first.
// Latency: done pulses NUM_BITS+1 edges after the accept edge; new start taken only in IDLE.
// Backpressure: start is ignored while busy or during the done cycle; caller must re-present it.
module serial_subtractor_nbit
    import serial_subtractor_nbit_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] difference,
    output logic                borrow_out
);

    localparam int               CNT_W    = $clog2(NUM_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state;
    state_t              next_state;
    logic [NUM_BITS-1:0] a_sr;
    logic [NUM_BITS-1:0] b_sr;
    logic [NUM_BITS-1:0] res_sr;
    logic                br;
    logic [CNT_W-1:0]    cnt;
    logic                bit_d;
    logic                bit_bout;
    logic                last_bit;

    full_subtractor_1bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // The counter reaches NUM_BITS only on the edge that leaves SHIFT, so it never wraps.
    assign last_bit = (cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: DONE always falls back to IDLE so start is only ever seen in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs; results are only written on the final bit, so partial
    // results never reach the difference port and an aborted operation leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            borrow_out <= 1'b0;
        end else begin
            busy <= (next_state == SHIFT);
            done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        br     <= borrow_in;
                        res_sr <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= bit_bout;
                    res_sr <= {bit_d, res_sr[NUM_BITS-1:1]};
                    cnt    <= cnt + CNT_ONE;
                    if (last_bit) begin
                        difference <= {bit_d, res_sr[NUM_BITS-1:1]};
                        borrow_out <= bit_bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor_nbit.md
SERIAL_SUBTRACTOR_NBIT -- requirements
Module: serial_subtractor_nbit

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter: NUM_BITS, default 4, operand and difference width (legal range 2..32).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-006 Port: a  input  NUM_BITS  minuend (unsigned), sampled on the edge that accepts start.
REQ-007 Port: b  input  NUM_BITS  subtrahend (unsigned), sampled with a.
REQ-008 Port: borrow_in  input  1  incoming borrow, sampled with a.
REQ-009 Port: busy  output  1  high while an operation is in progress (SHIFT state).
REQ-010 Port: done  output  1  single-cycle pulse marking a valid result.
REQ-011 Port: difference  output  NUM_BITS  registered result, a - b - borrow_in modulo 2^NUM_BITS.
REQ-012 Port: borrow_out  output  1  registered final borrow, high when a < b + borrow_in.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 In IDLE, start=1 at an edge SHALL load a, b and borrow_in into internal shift/borrow registers, clear the bit counter, and enter SHIFT.
REQ-015 In SHIFT, each edge SHALL process one bit, LSB first: d = a0 ^ b0 ^ br; next br = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-016 In SHIFT, each edge SHALL shift d into the partial-result register from the MSB end, shift the operand registers right, and increment the counter.
REQ-017 After the NUM_BITS-th SHIFT edge, the FSM SHALL enter DONE and load difference and borrow_out from the partial result and final borrow.
REQ-018 done SHALL be high only in DONE, exactly NUM_BITS+1 edges after the edge that accepted start, and for exactly one cycle.
REQ-019 DONE SHALL return unconditionally to IDLE on the next edge; a start asserted during DONE SHALL be ignored.
REQ-020 start asserted in SHIFT SHALL be ignored, and operand inputs SHALL not affect an operation in progress.
REQ-021 difference and borrow_out SHALL hold their values from the last completion until the next completion or reset.
REQ-022 Throughput: back-to-back start SHALL be accepted no sooner than one cycle after done, giving a minimum period of NUM_BITS+2 cycles.
REQ-023 Boundary cases: a=b with borrow_in=0 SHALL give difference 0 and borrow_out 0; a=0, b=0, borrow_in=1 SHALL give all ones and borrow_out 1.
REQ-024 The counter SHALL be $clog2(NUM_BITS+1) bits wide and SHALL not wrap during an operation.

Reset
REQ-025 With rst=1 at an edge, state SHALL go to IDLE, and busy, done, difference, borrow_out, the counter and all internal registers SHALL be 0.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 A reset asserted mid-SHIFT SHALL abort the operation with no done pulse, and no partial result SHALL ever appear on difference.

Structure
REQ-028 A shared package SHALL hold the state enum typedef (IDLE, SHIFT, DONE) and the default-width constant.
REQ-029 The block SHALL instantiate one combinational sub-module, full_subtractor_1bit (ports a, b, bin, d, bout), for the per-bit cell.
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 Reset, then a=5, b=3, borrow_in=0, start for 1 cycle -> busy for 4 cycles, done pulse at edge 5, difference=4'h2, borrow_out=0.
REQ-032 a=3, b=5, borrow_in=0 -> difference=4'hE, borrow_out=1; then a=4'hF, b=4'hF, borrow_in=1 -> difference=4'hF, borrow_out=1.
REQ-033 Pulse start again with a=0, b=0 two cycles into busy -> no new operation, and exactly one done with the original result.
REQ-034 Assert rst at SHIFT edge 2 -> no done, outputs 0, IDLE; a following start with a=9, b=1 -> difference=4'h8.
REQ-035 Run all 512 combinations of {borrow_in, b, a} with NUM_BITS=4 -> each {borrow_out, difference} matches a - b - borrow_in, with done latency always 5 edges.
REQ-036 Rerun REQ-031 and REQ-035 with NUM_BITS=8, using 1000 random vectors for the REQ-035 part -> latency 9 edges and all results correct.
